hazard_fetch_ctrl: RTL

Controller that sequences the program counter and the IF/ID and ID/EX pipeline registers of the pipelined MIPS core. It chooses the next PC (sequential, jump, taken branch) and generates the PC stall, pipeline-register write-enable and flush controls. It handles load-use hazards, control hazards and instruction-memory wait states, and holds a pending redirect that arrives while fetch is blocked. It sits between the ID/EX stage decode outputs, the instruction-memory handshake and the PC register, whose write-hold input it drives.

---
 rtl/hazard_fetch_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_fetch_ctrl.sv
// Next-PC selection and pipeline-register control for the MIPS core.
// Resolves load-use and control hazards and imem waits, and holds a pending redirect.
module hazard_fetch_ctrl #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [4:0]        id_rs_i,
   input  logic [4:0]        id_rt_i,
   input  logic              id_jump_i,
   input  logic [ADDR_W-1:0] id_jump_tgt_i,
   input  logic              ex_mem_read_i,
   input  logic [4:0]        ex_rt_i,
   input  logic              ex_br_taken_i,
   input  logic [ADDR_W-1:0] ex_br_tgt_i,
   input  logic              imem_ready_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] pc_next_o,
   output logic              pc_stall_o,
   output logic              ifid_write_o,
   output logic              ifid_flush_o,
   output logic              idex_flush_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic {S_RUN, S_WAIT} state_e;

   state_e              state_q, state_d;
   logic                redir_vld_q, redir_vld_d;
   logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic                lu;
   logic [ADDR_W-1:0]   pc_seq;

   assign lu = ex_mem_read_i && (ex_rt_i != 5'd0) &&
               ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
   assign pc_seq = pc_i + ADDR_W'(4);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_RUN;
         redir_vld_q <= 1'b0;
         redir_pc_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         redir_vld_q <= redir_vld_d;
         redir_pc_q  <= redir_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      redir_vld_d = redir_vld_q;
      redir_pc_d  = redir_pc_q;
      unique case (state_q)
         S_RUN: begin
            if (!ex_br_taken_i && !imem_ready_i)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ex_br_taken_i) begin
               redir_vld_d = 1'b1;
               redir_pc_d  = ex_br_tgt_i;
            end
            if (imem_ready_i) begin
               state_d     = S_RUN;
               redir_vld_d = 1'b0;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      imem_req_o   = 1'b1;
      pc_next_o    = pc_seq;
      pc_stall_o   = 1'b0;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      if (rst_i) begin
         imem_req_o   = 1'b0;
         pc_next_o    = pc_i;
         pc_stall_o   = 1'b1;
         ifid_write_o = 1'b0;
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (state_q == S_RUN) begin
         if (ex_br_taken_i) begin
            pc_next_o    = ex_br_tgt_i;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
         end else if (!imem_ready_i) begin
            pc_next_o    = pc_i;
            pc_stall_o   = 1'b1;
            ifid_write_o = 1'b0;
            idex_flush_o = lu;
         end else if (lu) begin
            pc_next_o    = pc_i;
            pc_stall_o   = 1'b1;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
         end else if (id_jump_i) begin
            pc_next_o    = id_jump_tgt_i;
            ifid_flush_o = 1'b1;
         end
      end else begin
         idex_flush_o = lu;
         if (!imem_ready_i) begin
            pc_next_o    = pc_i;
            pc_stall_o   = 1'b1;
            ifid_flush_o = 1'b1;
         end else if (ex_br_taken_i || redir_vld_q) begin
            // fetched word is wrong-path: drop it and redirect now
            pc_next_o    = ex_br_taken_i ? ex_br_tgt_i : redir_pc_q;
            ifid_flush_o = 1'b1;
         end else if (lu) begin
            pc_next_o    = pc_i;
            pc_stall_o   = 1'b1;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
         end else if (id_jump_i) begin
            pc_next_o    = id_jump_tgt_i;
            ifid_flush_o = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule
